// File: rtl/uart_rx_oversampled.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_oversampled
// Brief    : Oversampled UART receiver with mid-bit sampling and valid/ready output
// Revision : 1.0
// ============================================================================
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxenable,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] c_cnt_mid  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATA_BITS - 1);
    localparam logic             c_odd      = (PARITY_ODD != 0);
    localparam logic             c_par_en   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic                   r_rxen_q;
    logic                   r_rx_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [DATA_BITS-1:0]   w_shreg_next;
    logic                   r_perr;
    logic                   w_perr_next;
    logic                   w_load;
    logic                   w_tick;

    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_perr_out;
    logic                   r_overrun;

    assign w_tick = rxenable & ~r_rxen_q;

    // Line synchronizer, sample-tick edge detector and last-tick line level
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rxen_q  <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rxen_q  <= rxenable;
            if (w_tick) begin
                r_rx_prev <= r_rx_s;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shreg <= w_shreg_next;
            r_perr  <= w_perr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shreg_next = r_shreg;
        w_perr_next  = r_perr;
        w_load       = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    // A falling edge between ticks is required, so a stuck-low line never restarts
                    if (!r_rx_s && r_rx_prev) begin
                        w_state_next = S_START;
                        w_cnt_next   = '0;
                    end
                end
                S_START: begin
                    if (r_cnt == c_cnt_mid) begin
                        if (r_rx_s) begin
                            w_state_next = S_IDLE;
                        end else begin
                            w_state_next = S_DATA;
                            w_cnt_next   = '0;
                            w_idx_next   = '0;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_next          = '0;
                        w_shreg_next[r_idx] = r_rx_s;
                        if (r_idx == c_idx_last) begin
                            w_state_next = c_par_en ? S_PARITY : S_STOP;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_next   = '0;
                        w_perr_next  = ((^r_shreg) ^ r_rx_s) != c_odd;
                        w_state_next = S_STOP;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_next   = '0;
                        w_state_next = S_IDLE;
                        w_load       = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Output holding register; a new frame takes priority over a same-cycle accept
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                r_data     <= r_shreg;
                r_ferr     <= ~r_rx_s;
                r_perr_out <= c_par_en & r_perr;
                r_valid    <= 1'b1;
                r_overrun  <= r_valid & ~rx_ready;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign frame_error  = r_ferr;
    assign parity_error = r_perr_out;
    assign overrun      = r_overrun;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for uart_rx_oversampled: directed frames, expected words queued at issue,
// compared by a monitor whenever a DUT presents a new word.
module tb_uart_rx_oversampled;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       rxenable;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_error, parity_error, overrun, busy;

    logic       rx_p;
    logic       rx_ready_p;
    logic [7:0] rx_data_p;
    logic       rx_valid_p, frame_error_p, parity_error_p, overrun_p, busy_p;

    int n_vec   = 0;
    int n_bad   = 0;
    int ovr_cnt = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q[$];
    exp_t q_p[$];

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .clock(clock), .reset(reset), .rxenable(rxenable), .rx(rx), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
        .parity_error(parity_error), .overrun(overrun), .busy(busy)
    );

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .clock(clock), .reset(reset), .rxenable(rxenable), .rx(rx_p), .rx_ready(rx_ready_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .frame_error(frame_error_p),
        .parity_error(parity_error_p), .overrun(overrun_p), .busy(busy_p)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One sample tick: rxenable low two clocks, then high two clocks
    task automatic tick();
        rxenable = 1'b0;
        repeat (2) @(posedge clock);
        #1 rxenable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input bit to_p, input logic v, input int n);
        if (to_p) rx_p = v;
        else      rx   = v;
        repeat (n) tick();
    endtask

    task automatic send_frame(input bit to_p, input logic [7:0] d, input logic par_en,
                              input logic par_b, input logic stop_b, input int idle);
        drive_bit(to_p, 1'b0, 8);
        for (int i = 0; i < 8; i++) drive_bit(to_p, d[i], 8);
        if (par_en) drive_bit(to_p, par_b, 8);
        drive_bit(to_p, stop_b, 8);
        drive_bit(to_p, 1'b1, idle);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
    endtask

    // Monitor: a new word is presented on a rising rx_valid or on an overwrite (overrun)
    initial begin
        logic pv;
        logic pvp;
        exp_t e;
        pv  = 1'b0;
        pvp = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (overrun) ovr_cnt++;
                if ((rx_valid && !pv) || overrun) begin
                    if (q.size() == 0) begin
                        check("unexpected_word", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        check("rx_data", rx_data, e.d);
                        check("frame_error", frame_error, e.fe);
                        check("parity_error", parity_error, e.pe);
                    end
                end
                if ((rx_valid_p && !pvp) || overrun_p) begin
                    if (q_p.size() == 0) begin
                        check("unexpected_word_p", q_p.size(), 1);
                    end else begin
                        e = q_p.pop_front();
                        check("rx_data_p", rx_data_p, e.d);
                        check("frame_error_p", frame_error_p, e.fe);
                        check("parity_error_p", parity_error_p, e.pe);
                    end
                end
            end
            pv  = rx_valid;
            pvp = rx_valid_p;
        end
    end

    initial begin
        reset      = 1'b1;
        rxenable   = 1'b0;
        rx         = 1'b1;
        rx_p       = 1'b1;
        rx_ready   = 1'b0;
        rx_ready_p = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_ferr", frame_error, 0);
        check("reset_perr", parity_error, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        drive_bit(0, 1'b1, 2);

        // Clean frame, held until accepted
        q.push_back(exp_t'{d: 8'hA5, fe: 1'b0, pe: 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 2);
        check("a5_valid", rx_valid, 1);
        check("a5_busy", busy, 0);
        repeat (5) @(posedge clock);
        #1 check("a5_valid_held", rx_valid, 1);
        accept();
        check("a5_valid_cleared", rx_valid, 0);
        check("a5_data_held", rx_data, 8'hA5);

        // False start: two low ticks then high
        drive_bit(0, 1'b0, 2);
        check("false_start_busy", busy, 1);
        drive_bit(0, 1'b1, 3);
        check("false_start_idle", busy, 0);
        drive_bit(0, 1'b1, 4);
        check("false_start_no_valid", rx_valid, 0);

        // Bad stop bit
        q.push_back(exp_t'{d: 8'h3C, fe: 1'b1, pe: 1'b0});
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 2);
        check("3c_valid", rx_valid, 1);
        check("3c_frame_error", frame_error, 1);
        accept();

        // Back-to-back frames without accept
        q.push_back(exp_t'{d: 8'h11, fe: 1'b0, pe: 1'b0});
        q.push_back(exp_t'{d: 8'h22, fe: 1'b0, pe: 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 0);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 2);
        check("overrun_pulses", ovr_cnt, 1);
        check("overrun_data", rx_data, 8'h22);
        check("overrun_valid", rx_valid, 1);
        accept();

        // Reset during bit 3 of 0x5A
        drive_bit(0, 1'b0, 8);
        drive_bit(0, 1'b0, 8);
        drive_bit(0, 1'b1, 8);
        drive_bit(0, 1'b0, 8);
        drive_bit(0, 1'b1, 4);
        check("midframe_busy", busy, 1);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("post_reset_busy", busy, 0);
        check("post_reset_valid", rx_valid, 0);
        check("post_reset_data", rx_data, 0);
        drive_bit(0, 1'b1, 4);
        q.push_back(exp_t'{d: 8'h7E, fe: 1'b0, pe: 1'b0});
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, 2);
        check("7e_valid", rx_valid, 1);
        accept();

        // Even parity on the parity-enabled instance
        q_p.push_back(exp_t'{d: 8'h01, fe: 1'b0, pe: 1'b1});
        send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1, 2);
        q_p.push_back(exp_t'{d: 8'h01, fe: 1'b0, pe: 1'b0});
        send_frame(1, 8'h01, 1'b1, 1'b1, 1'b1, 2);
        check("parity_valid_accepted", rx_valid_p, 0);

        drive_bit(0, 1'b1, 2);
        check("queue_drained", q.size(), 0);
        check("queue_p_drained", q_p.size(), 0);
        check("overrun_total", ovr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
